// File: rtl/uart_8250_rx.sv
// 8250-compatible UART receiver: synchronizes RX_I, oversamples it with a divisor-driven tick
// and reassembles 5-8 bit characters with parity/framing/break status behind a valid/ready handshake.
module uart_8250_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        RX_I,
    input  logic [15:0] DIVISOR_I,
    input  logic [7:0]  LCR_I,
    output logic [7:0]  DATA_O,
    output logic        VALID_O,
    input  logic        READY_I,
    output logic        PE_O,
    output logic        FE_O,
    output logic        BI_O,
    output logic        OVERRUN_O,
    output logic        BUSY_O
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] FULL = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs, rxs_d;
    logic [15:0]            tcnt, div_m1;
    logic                   tick;
    state_t                 state;
    logic [SW-1:0]          scnt;
    logic [2:0]             bcnt;
    logic [7:0]             shreg;
    logic [1:0]             cfg_wlen;
    logic                   cfg_pen, cfg_eps, cfg_stick;
    logic                   par_bit, exp_par, pe_c;

    assign rxs = sync[SYNC_STAGES-1];

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            sync  <= '1;
            rxs_d <= 1'b1;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], RX_I};
            rxs_d <= rxs;
        end
    end

    // Divisor 0 aliases to 1; the >= compare also recovers cleanly if the divisor shrinks mid-count.
    assign div_m1 = (DIVISOR_I == 16'd0) ? 16'd0 : DIVISOR_I - 16'd1;
    assign tick   = (tcnt >= div_m1);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) tcnt <= '0;
        else        tcnt <= tick ? 16'd0 : tcnt + 16'd1;
    end

    assign exp_par = cfg_stick ? ~cfg_eps : (cfg_eps ? ^shreg : ~^shreg);
    assign pe_c    = cfg_pen && (par_bit != exp_par);
    assign BUSY_O  = (state != IDLE);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state     <= IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            cfg_wlen  <= '0;
            cfg_pen   <= 1'b0;
            cfg_eps   <= 1'b0;
            cfg_stick <= 1'b0;
            par_bit   <= 1'b0;
            DATA_O    <= '0;
            VALID_O   <= 1'b0;
            PE_O      <= 1'b0;
            FE_O      <= 1'b0;
            BI_O      <= 1'b0;
            OVERRUN_O <= 1'b0;
        end else begin
            OVERRUN_O <= 1'b0;
            if (VALID_O && READY_I) VALID_O <= 1'b0;
            case (state)
                IDLE: if (rxs_d && !rxs) begin
                    state     <= START;
                    scnt      <= '0;
                    cfg_wlen  <= LCR_I[1:0];
                    cfg_pen   <= LCR_I[3];
                    cfg_eps   <= LCR_I[4];
                    cfg_stick <= LCR_I[5];
                end
                START: if (tick) begin
                    if (scnt == HALF) begin
                        if (rxs) state <= IDLE;
                        else begin
                            state   <= DATA;
                            scnt    <= '0;
                            bcnt    <= '0;
                            shreg   <= '0;
                            par_bit <= 1'b0;
                        end
                    end else scnt <= scnt + 1'b1;
                end
                DATA: if (tick) begin
                    if (scnt == FULL) begin
                        scnt        <= '0;
                        shreg[bcnt] <= rxs;
                        if (bcnt == 3'd4 + {1'b0, cfg_wlen}) state <= cfg_pen ? PARITY : STOP;
                        else                                  bcnt  <= bcnt + 3'd1;
                    end else scnt <= scnt + 1'b1;
                end
                PARITY: if (tick) begin
                    if (scnt == FULL) begin
                        scnt    <= '0;
                        par_bit <= rxs;
                        state   <= STOP;
                    end else scnt <= scnt + 1'b1;
                end
                STOP: if (tick) begin
                    if (scnt == FULL) begin
                        scnt  <= '0;
                        state <= IDLE;
                        // A held character that is not being taken this cycle wins; the new one is dropped.
                        if (!VALID_O || READY_I) begin
                            DATA_O  <= shreg;
                            PE_O    <= pe_c;
                            FE_O    <= !rxs;
                            BI_O    <= (shreg == 8'h00) && !par_bit && !rxs;
                            VALID_O <= 1'b1;
                        end else OVERRUN_O <= 1'b1;
                    end else scnt <= scnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_8250_rx.sv
// Scoreboard bench for uart_8250_rx: frames are driven bit-serially, expected characters queued,
// and checked when the receiver hands them over.
module tb_uart_8250_rx;
    logic        CLK_I = 1'b0, RST_I = 1'b0, RX_I = 1'b1, READY_I = 1'b1;
    logic [15:0] DIVISOR_I = 16'd1;
    logic [7:0]  LCR_I = 8'h03;
    logic [7:0]  DATA_O;
    logic        VALID_O, PE_O, FE_O, BI_O, OVERRUN_O, BUSY_O;

    uart_8250_rx dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .RX_I(RX_I), .DIVISOR_I(DIVISOR_I), .LCR_I(LCR_I),
        .DATA_O(DATA_O), .VALID_O(VALID_O), .READY_I(READY_I), .PE_O(PE_O), .FE_O(FE_O),
        .BI_O(BI_O), .OVERRUN_O(OVERRUN_O), .BUSY_O(BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct packed {logic [7:0] d; logic pe, fe, bi;} exp_t;
    exp_t sbq[$];
    int   nvec = 0, nerr = 0;
    int   cyc = 0, chars = 0, ovr_cnt = 0, vrise_cyc = -1, t_start = 0;
    logic vprev = 1'b0;

    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK_I) begin
        if (OVERRUN_O) ovr_cnt++;
        if (VALID_O && !vprev) vrise_cyc = cyc;
        vprev = VALID_O;
        if (RST_I && VALID_O && READY_I) begin
            chars++;
            chk("sb_avail", 32'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("char", {DATA_O, PE_O, FE_O, BI_O}, {e.d, e.pe, e.fe, e.bi});
            end
        end
    end

    task automatic drive_bit(input logic b, input int clks);
        RX_I = b;
        repeat (clks) @(posedge CLK_I);
        #1;
    endtask

    task automatic send_char(input logic [7:0] d, input int nb, input logic pen, input logic pbit,
                             input logic stop, input logic push, input int bclk);
        exp_t e;
        logic [7:0] m, dm, ep;
        m  = 8'hFF >> (8 - nb);
        dm = d & m;
        ep = LCR_I[5] ? {7'd0, ~LCR_I[4]} : (LCR_I[4] ? {7'd0, ^dm} : {7'd0, ~^dm});
        e.d  = dm;
        e.pe = pen && (pbit != ep[0]);
        e.fe = !stop;
        e.bi = (dm == 8'h00) && (!pen || !pbit) && !stop;
        if (push) sbq.push_back(e);
        t_start = cyc;
        drive_bit(1'b0, bclk);
        for (int i = 0; i < nb; i++) drive_bit(d[i], bclk);
        if (pen) drive_bit(pbit, bclk);
        drive_bit(stop, bclk);
        drive_bit(1'b1, bclk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < budget) begin
            @(negedge CLK_I);
            n++;
        end
        chk("drain_timeout", 32'(sbq.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n;
        logic seen;
        repeat (3) @(negedge CLK_I);
        chk("reset_outs", {DATA_O, VALID_O, PE_O, FE_O, BI_O, OVERRUN_O, BUSY_O}, 0);
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        repeat (5) @(posedge CLK_I); #1;

        // 8N1 A5 at divisor 1, plus handover latency from the start edge
        send_char(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        drain(50);
        chk("latency_a5", 32'(vrise_cyc - t_start), 155);

        // 7 bits even parity, good then bad parity bit
        LCR_I = 8'h1A;
        send_char(8'h55, 7, 1'b1, 1'b0, 1'b1, 1'b1, 16);
        send_char(8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b1, 16);
        drain(50);

        // odd parity and stick parity variants
        LCR_I = 8'h0B;
        send_char(8'h3A, 8, 1'b1, 1'b1, 1'b1, 1'b1, 16);
        LCR_I = 8'h39;
        send_char(8'h1F, 6, 1'b1, 1'b1, 1'b1, 1'b1, 16);
        drain(50);

        // held-low break: exactly one character
        LCR_I = 8'h03;
        c0 = chars;
        sbq.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1, bi: 1'b1});
        drive_bit(1'b0, 320);
        drive_bit(1'b1, 100);
        drain(50);
        chk("break_count", 32'(chars - c0), 1);

        // short glitch is rejected as a false start
        c0 = chars;
        drive_bit(1'b0, 4);
        RX_I = 1'b1;
        seen = 1'b0;
        n = 0;
        do begin
            @(negedge CLK_I);
            n++;
            if (BUSY_O) seen = 1'b1;
        end while ((BUSY_O || !seen) && n < 30);
        chk("glitch_busy_seen", 32'(seen), 1);
        chk("glitch_busy_clr", 32'(n <= 8), 1);
        repeat (20) @(negedge CLK_I);
        chk("glitch_no_char", 32'(chars - c0), 0);

        // overrun while the consumer stalls
        @(posedge CLK_I); #1;
        READY_I = 1'b0;
        ovr_cnt = 0;
        send_char(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        send_char(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 16);
        @(negedge CLK_I);
        chk("ovr_pulses", 32'(ovr_cnt), 1);
        chk("ovr_hold", {VALID_O, DATA_O}, {1'b1, 8'h11});
        @(posedge CLK_I); #1;
        READY_I = 1'b1;
        drain(10);
        repeat (2) @(negedge CLK_I);
        chk("ovr_valid_drop", 32'(VALID_O), 0);

        // reset in the middle of a frame at divisor 3
        DIVISOR_I = 16'd3;
        repeat (10) @(posedge CLK_I); #1;
        c0 = chars;
        drive_bit(1'b0, 48);
        drive_bit(1'b0, 48);
        drive_bit(1'b0, 48);
        drive_bit(1'b1, 30);
        RST_I = 1'b0;
        RX_I  = 1'b1;
        @(negedge CLK_I);
        chk("midreset_outs", {DATA_O, VALID_O, PE_O, FE_O, BI_O, OVERRUN_O, BUSY_O}, 0);
        repeat (4) @(posedge CLK_I); #1;
        RST_I = 1'b1;
        repeat (96) @(posedge CLK_I); #1;
        chk("midreset_no_char", 32'(chars - c0), 0);
        send_char(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 48);
        drain(200);
        chk("midreset_count", 32'(chars - c0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
